// File: rtl/jtag_dr_pkg.sv
// Shared types and helpers for the JTAG user data register chains.
package jtag_dr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURED,
    SHIFTING
  } dr_state_t;

  // Counter must reach WIDTH+1 so an over-long scan is distinguishable from an exact one.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/jtag_user_dr_if.sv
// JTCK-domain TAP strobes feeding one user chain, and that chain's TDO mux input.
interface jtag_user_dr_if;
  logic JTDI;
  logic JCE;
  logic JSHIFT;
  logic JUPDATE;
  logic JTDO;

  modport master (output JTDI, output JCE, output JSHIFT, output JUPDATE, input JTDO);
  modport slave  (input JTDI, input JCE, input JSHIFT, input JUPDATE, output JTDO);
endinterface

// File: rtl/jtag_user_dr.sv
// JTAG user data register: capture/shift/update with a committed parallel output.
// Optional scan-length check enabled by defining JTAG_DR_LENCHECK_EN.
module jtag_user_dr
  import jtag_dr_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               CAPTURE_EXT = 1'b0
) (
  input  logic             JTCK,
  input  logic             JRST,
  jtag_user_dr_if.slave    tap,
  input  logic [WIDTH-1:0] capture_in,
  output logic [WIDTH-1:0] data_out,
  output logic             update_pulse,
  output logic             len_err
);

  dr_state_t        state;
  logic [WIDTH-1:0] shift_reg;
  logic             commit_ok;

  assign tap.JTDO = shift_reg[0];

`ifdef JTAG_DR_LENCHECK_EN
  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(WIDTH + 1);

  // Shift count only matters when the length check is built in.
  logic [CW-1:0] bit_cnt;

  assign commit_ok = (state == SHIFTING) && (bit_cnt == CNT_FULL);
`else
  assign commit_ok = 1'b1;
  assign len_err   = 1'b0;
`endif

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // and the async reset branch covers every register this block writes.
  always_ff @(posedge JTCK or posedge JRST) begin
    if (JRST) begin
      state        <= IDLE;
      shift_reg    <= '0;
      data_out     <= RESET_VALUE;
      update_pulse <= 1'b0;
`ifdef JTAG_DR_LENCHECK_EN
      bit_cnt      <= '0;
      len_err      <= 1'b0;
`endif
    end else begin
      update_pulse <= 1'b0;
      if (tap.JUPDATE) begin
        if (state != IDLE) begin
          if (commit_ok) begin
            data_out     <= shift_reg;
            update_pulse <= 1'b1;
          end
`ifdef JTAG_DR_LENCHECK_EN
          else begin
            len_err <= 1'b1;
          end
`endif
        end
        state <= IDLE;
      end else if (tap.JCE && !tap.JSHIFT) begin
        shift_reg <= CAPTURE_EXT ? capture_in : data_out;
        state     <= CAPTURED;
`ifdef JTAG_DR_LENCHECK_EN
        bit_cnt   <= '0;
        len_err   <= 1'b0;
`endif
      end else if (tap.JCE && tap.JSHIFT && (state != IDLE)) begin
        // LSB leaves on JTDO first; JTDI enters at the top.
        shift_reg <= {tap.JTDI, shift_reg[WIDTH-1:1]};
        state     <= SHIFTING;
`ifdef JTAG_DR_LENCHECK_EN
        if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_jtag_user_dr.sv
// Directed bench for jtag_user_dr: one readback chain and one status-capture chain.
module tb_jtag_user_dr;
  localparam int W = 8;

`ifdef JTAG_DR_LENCHECK_EN
  localparam bit LENCHK = 1'b1;
`else
  localparam bit LENCHK = 1'b0;
`endif

  logic         jtck = 1'b0;
  logic         jrst = 1'b1;
  logic [W-1:0] cap_a = 8'h00;
  logic [W-1:0] cap_b = 8'h81;
  logic [W-1:0] dout_a, dout_b;
  logic         upd_a, upd_b, lerr_a, lerr_b;
  logic [W-1:0] prev, pat, ext;
  int           checks = 0;
  int           failures = 0;

  jtag_user_dr_if tap_a ();
  jtag_user_dr_if tap_b ();

  jtag_user_dr #(.WIDTH(W), .RESET_VALUE(8'hA5), .CAPTURE_EXT(1'b0)) u_a (
    .JTCK(jtck), .JRST(jrst), .tap(tap_a), .capture_in(cap_a),
    .data_out(dout_a), .update_pulse(upd_a), .len_err(lerr_a)
  );

  jtag_user_dr #(.WIDTH(W), .RESET_VALUE(8'h00), .CAPTURE_EXT(1'b1)) u_b (
    .JTCK(jtck), .JRST(jrst), .tap(tap_b), .capture_in(cap_b),
    .data_out(dout_b), .update_pulse(upd_b), .len_err(lerr_b)
  );

  always #5 jtck = ~jtck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic sh, input logic up, input logic tdi);
    tap_a.JCE = ce; tap_a.JSHIFT = sh; tap_a.JUPDATE = up; tap_a.JTDI = tdi;
    tap_b.JCE = ce; tap_b.JSHIFT = sh; tap_b.JUPDATE = up; tap_b.JTDI = tdi;
  endtask

  // Apply one set of strobes across a rising edge; return at the falling edge.
  task automatic cycle(input logic ce, input logic sh, input logic up, input logic tdi);
    drive(ce, sh, up, tdi);
    @(posedge jtck);
    @(negedge jtck);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    @(negedge jtck);
    check("rst_dout", dout_a, 8'hA5);
    check("rst_jtdo", tap_a.JTDO, 1'b0);
    check("rst_upd", upd_a, 1'b0);
    check("rst_lerr", lerr_a, 1'b0);
    check("rst_dout_b", dout_b, 8'h00);
    #2 jrst = 1'b0;

    // Full scan: readback of A5 out, 3C in; external capture of 81 on chain b
    prev = 8'hA5;
    pat  = 8'h3C;
    ext  = 8'h81;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      check($sformatf("scan_tdo%0d", i), tap_a.JTDO, prev[i]);
      check($sformatf("ext_tdo%0d", i), tap_b.JTDO, ext[i]);
      cycle(1'b1, 1'b1, 1'b0, pat[i]);
    end
    check("scan_upd_pre", upd_a, 1'b0);
    check("scan_dout_pre", dout_a, 8'hA5);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("scan_dout", dout_a, 8'h3C);
    check("scan_upd", upd_a, 1'b1);
    check("scan_lerr", lerr_a, 1'b0);
    check("ext_dout", dout_b, 8'h3C);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("scan_upd_off", upd_a, 1'b0);
    check("scan_dout_hold", dout_a, 8'h3C);

    // Update beats shift; back-to-back update and idle shift do nothing
    pat = 8'h5A;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) cycle(1'b1, 1'b1, 1'b0, pat[i]);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("pri_dout", dout_a, 8'h5A);
    check("pri_upd", upd_a, 1'b1);
    check("pri_noshift_tdo", tap_a.JTDO, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b_upd", upd_a, 1'b0);
    check("b2b_dout", dout_a, 8'h5A);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("idle_shift_tdo", tap_a.JTDO, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_upd", upd_a, 1'b0);

    // Short scan: five 1s into captured 5A gives FA
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("short_dout", dout_a, LENCHK ? 8'h5A : 8'hFA);
    check("short_upd", upd_a, LENCHK ? 1'b0 : 1'b1);
    check("short_lerr", lerr_a, LENCHK ? 1'b1 : 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("short_lerr_hold", lerr_a, LENCHK ? 1'b1 : 1'b0);
    check("short_upd_off", upd_a, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("short_lerr_clr", lerr_a, 1'b0);

    // Over-long scan: C2 then one extra 1 leaves E1 in the shift register
    pat = 8'hC2;
    for (int i = 0; i < W; i++) cycle(1'b1, 1'b1, 1'b0, pat[i]);
    check("over_tdo8", tap_a.JTDO, pat[0]);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("over_tdo9", tap_a.JTDO, pat[1]);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("over_dout", dout_a, LENCHK ? 8'h5A : 8'hE1);
    check("over_upd", upd_a, LENCHK ? 1'b0 : 1'b1);
    check("over_lerr", lerr_a, LENCHK ? 1'b1 : 1'b0);

    // Reset mid-scan, asserted while the clock is low
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_lerr_clr", lerr_a, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2 jrst = 1'b1;
    #1;
    check("mid_rst_dout", dout_a, 8'hA5);
    check("mid_rst_jtdo", tap_a.JTDO, 1'b0);
    check("mid_rst_upd", upd_a, 1'b0);
    check("mid_rst_lerr", lerr_a, 1'b0);
    #1 jrst = 1'b0;
    @(negedge jtck);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_dout", dout_a, 8'hA5);
    check("post_rst_upd", upd_a, 1'b0);
    check("post_rst_jtdo", tap_a.JTDO, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_user_dr.md
# jtag_user_dr

Parametrised JTAG user data register with WIDTH bits, a selectable capture source, a committed parallel output and a one-cycle update strobe. When JTAG_DR_LENCHECK_EN is defined, it also checks scan length. It sits behind the TAP controller's user-chain decode, one instance per user chain. It receives the JTCK-domain TAP strobes and drives one chain's TDO mux input plus fabric-facing control bits such as LED columns and mode registers.

## Interface
- WIDTH, 4: data register length in bits, ≥ 2.
- RESET_VALUE, '0: value of `data_out` after reset.
- CAPTURE_EXT, 0: capture source. 0 loads `data_out` (readback); 1 loads `capture_in` (status).

- JTCK  in  1: TAP clock; all state changes on its rising edge.
- JRST  in  1: reset, asynchronous, active-high.
- JTDI  in  1: serial data in.
- JCE  in  1: chain enable; this chain's instruction is selected and the TAP is in Capture-DR/Shift-DR.
- JSHIFT  in  1: Shift-DR qualifier (with JCE).
- JUPDATE  in  1: Update-DR strobe.
- capture_in  in  WIDTH: parallel status sampled at capture when CAPTURE_EXT=1.
- JTDO  out  1: serial out, equals shift_reg[0] (combinational from register).
- data_out  out  WIDTH: committed register contents.
- update_pulse  out  1: high for exactly one cycle after each commit.
- len_err  out  1: sticky scan-length error. Held 0 when the macro is absent.

## Operation
- State register with states IDLE, CAPTURED and SHIFTING, plus shift_reg[WIDTH-1:0] and bit_cnt.
- bit_cnt is $clog2(WIDTH+2) bits and saturates at WIDTH+1.
- Per edge, priority is JUPDATE > capture > shift.
- **Update** (JUPDATE=1, JCE ignored):
  - State IDLE: no effect.
  - Otherwise, if commit is permitted: data_out <= shift_reg and update_pulse <= 1.
  - Then state <= IDLE.
- **Commit permission:**
  - Macro absent: always.
  - Macro present: only if state=SHIFTING and bit_cnt==WIDTH. Otherwise len_err <= 1 and data_out is unchanged.
- **Capture** (JCE=1, JSHIFT=0, JUPDATE=0):
  - shift_reg <= (CAPTURE_EXT ? capture_in : data_out).
  - bit_cnt <= 0, len_err <= 0, state <= CAPTURED.
  - Legal from any state; a repeated capture restarts the scan.
- **Shift** (JCE=1, JSHIFT=1, JUPDATE=0, state≠IDLE):
  - shift_reg <= {JTDI, shift_reg[WIDTH-1:1]}, LSB out first.
  - bit_cnt <= sat(bit_cnt+1); state <= SHIFTING.
  - A shift while IDLE is ignored, leaving shift_reg and JTDO unchanged.
- JCE=0 with JUPDATE=0: hold all state.
- update_pulse is 0 on every cycle not immediately following a commit.

## Timing
- Reset values: data_out=RESET_VALUE, shift_reg=0, JTDO=0, bit_cnt=0, state=IDLE, update_pulse=0, len_err=0.
- Reset is effective immediately and asynchronously; deassertion is synchronous to JTCK.
- JTDO presents bit n before shift edge n+1. Capture-to-first-bit latency is 0: bit 0 is on JTDO the cycle after the capture edge.
- data_out changes on the JUPDATE edge; update_pulse is high during the following cycle only.
- Back-to-back updates on consecutive cycles: the first commits, and the second sees IDLE and does nothing.
- Reset mid-scan discards shift_reg contents; a later JUPDATE without a new capture has no effect.
- Shifting more than WIDTH bits:
  - The surplus shifts through, with JTDI bits appearing on JTDO after WIDTH shifts.
  - bit_cnt saturates at WIDTH+1, so the scan fails the length check.

## Configuration
- JTAG_DR_LENCHECK_EN defined: commit requires exactly WIDTH shifts since the last capture. Otherwise data_out is preserved, no update_pulse is issued, and len_err is set until the next capture or reset.
- Macro absent: every update outside IDLE commits (standard IEEE 1149.1 behaviour), and len_err is tied to 0.

## Structure
- Package jtag_dr_pkg holds:
  - typedef enum logic [1:0] {IDLE, CAPTURED, SHIFTING} dr_state_t.
  - The function cnt_width(WIDTH) returning $clog2(WIDTH+2).
- No sub-module; a single flat module.
- The existing LED-column chain becomes an instance with WIDTH=4, CAPTURE_EXT=0, driving the LED column outputs from data_out.

## Test plan
- **Reset:** WIDTH=8, RESET_VALUE=8'hA5; pulse JRST mid-cycle → data_out=8'hA5 immediately, JTDO=0, update_pulse=0.
- **Full scan:** capture, shift 8 bits of 8'h3C LSB-first, update → data_out=8'h3C and update_pulse high exactly one cycle. JTDO carried the previous data_out (8'hA5) LSB-first.
- **External capture:** CAPTURE_EXT=1, capture_in=8'h81; capture then 8 shifts → JTDO sequence 1,0,0,0,0,0,0,1.
- **Short scan, macro defined:** 5 shifts then update → data_out unchanged, no update_pulse, len_err=1. The next capture clears len_err.
- **Short scan, macro absent:** 5 shifts then update → data_out = captured value shifted right 5 with the 5 JTDI bits in the top bits, update_pulse=1.
- **Priority and idle:** JUPDATE asserted together with JCE+JSHIFT → commit, no shift. A second JUPDATE on the next cycle → no commit. Shift while IDLE → shift_reg unchanged.
